// File: rtl/csr_access_pkg.sv
// Shared Zicsr encodings for the CSR access unit: funct3 values, CSR file op codes,
// access-field bit positions of a CSR address, and the sequencer state type.
package csr_access_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    CSR_OP_SET   = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_CLEAR = 2'd2
  } csr_op_e;

  // addr[11:10] == 2'b11 marks a read-only CSR; addr[9:8] is the lowest privilege allowed
  localparam int         CSR_RW_HI   = 11;
  localparam int         CSR_RW_LO   = 10;
  localparam int         CSR_PRIV_HI = 9;
  localparam int         CSR_PRIV_LO = 8;
  localparam logic [1:0] CSR_RW_RO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/csr_access_decode.sv
// Combinational Zicsr decode: funct3 -> CSR file op, operand select, write intent,
// and the illegality that depends only on the instruction itself.
module csr_access_decode
  import csr_access_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic [2:0]                funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] rs1_data_i,
  input  logic [4:0]                rs1_idx_i,
  output logic [1:0]                op_o,
  output logic [CSR_DATA_WIDTH-1:0] operand_o,
  output logic                      write_intent_o,
  output logic                      illegal_o
);

  logic [CSR_DATA_WIDTH-1:0] src;
  logic                      bad_f3;

  always_comb begin
    op_o           = CSR_OP_SET;
    operand_o      = '0;
    write_intent_o = 1'b0;
    bad_f3         = 1'b0;
    src            = funct3_i[2] ? {{(CSR_DATA_WIDTH-5){1'b0}}, rs1_idx_i} : rs1_data_i;
    // set/clear with rs1_idx == 0 falls through as a pure read: set with a zero mask
    case (funct3_i)
      F3_CSRRW, F3_CSRRWI: begin
        op_o           = CSR_OP_WRITE;
        operand_o      = src;
        write_intent_o = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        if (rs1_idx_i != '0) begin
          op_o           = CSR_OP_SET;
          operand_o      = src;
          write_intent_o = 1'b1;
        end
      end
      F3_CSRRC, F3_CSRRCI: begin
        if (rs1_idx_i != '0) begin
          op_o           = CSR_OP_CLEAR;
          operand_o      = src;
          write_intent_o = 1'b1;
        end
      end
      default: bad_f3 = 1'b1;
    endcase
    illegal_o = bad_f3 ||
                (write_intent_o && (addr_i[CSR_RW_HI:CSR_RW_LO] == CSR_RW_RO));
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr sequencer between execute and the CSR file: accept, legality check, issue, wait
// out the busy window, respond. Define CSR_PRIV_CHECK_EN to add the priv_i privilege check.
module csr_access_unit
  import csr_access_pkg::*;
#(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int BUSY_TIMEOUT   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
`ifdef CSR_PRIV_CHECK_EN
  input  logic [1:0]                priv_i,
`endif
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] req_rs1_data_i,
  input  logic [4:0]                req_rs1_idx_i,
  input  logic [4:0]                req_rd_idx_i,
  output logic                      csr_en_o,
  output logic [1:0]                csr_op_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  input  logic                      csr_busy_i,
  input  logic                      csr_exists_i,
  input  logic                      csr_ro_i,
  output logic                      rsp_valid_o,
  output logic                      rsp_rd_we_o,
  output logic [4:0]                rsp_rd_idx_o,
  output logic [CSR_DATA_WIDTH-1:0] rsp_rd_data_o,
  output logic                      rsp_illegal_o,
  output logic                      rsp_timeout_o
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT);

  state_e                    state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CSR_DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [4:0]                rs1_idx_q, rs1_idx_d;
  logic [4:0]                rd_idx_q, rd_idx_d;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      seen_busy_q, seen_busy_d;
  logic                      illegal_q, illegal_d;
  logic                      timeout_q, timeout_d;

  logic [1:0]                dec_op;
  logic [CSR_DATA_WIDTH-1:0] dec_operand;
  logic                      dec_write_intent;
  logic                      dec_illegal;
  logic                      priv_bad;
  logic                      issue_illegal;
  logic                      en;
  logic                      in_resp;

  csr_access_decode #(
    .CSR_DATA_WIDTH (CSR_DATA_WIDTH),
    .CSR_ADDR_WIDTH (CSR_ADDR_WIDTH)
  ) u_decode (
    .funct3_i       (funct3_q),
    .addr_i         (addr_q),
    .rs1_data_i     (rs1_data_q),
    .rs1_idx_i      (rs1_idx_q),
    .op_o           (dec_op),
    .operand_o      (dec_operand),
    .write_intent_o (dec_write_intent),
    .illegal_o      (dec_illegal)
  );

`ifdef CSR_PRIV_CHECK_EN
  assign priv_bad = (addr_q[CSR_PRIV_HI:CSR_PRIV_LO] > priv_i);
`else
  assign priv_bad = 1'b0;
`endif

  // exists/ro come back combinationally from the file for the address already on csr_addr_o
  assign issue_illegal = dec_illegal || !csr_exists_i || csr_ro_i || priv_bad;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    rs1_data_d  = rs1_data_q;
    rs1_idx_d   = rs1_idx_q;
    rd_idx_d    = rd_idx_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    en          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          funct3_d   = req_funct3_i;
          addr_d     = req_addr_i;
          rs1_data_d = req_rs1_data_i;
          rs1_idx_d  = req_rs1_idx_i;
          rd_idx_d   = req_rd_idx_i;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        seen_busy_d = 1'b0;
        cnt_d       = '0;
        timeout_d   = 1'b0;
        rdata_d     = '0;
        illegal_d   = issue_illegal;
        en          = !issue_illegal;
        state_d     = issue_illegal ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        // completion wins over timeout when both land on the same cycle
        if (seen_busy_q && !csr_busy_i) begin
          rdata_d = csr_data_i;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          illegal_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          seen_busy_d = seen_busy_q | csr_busy_i;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      addr_q      <= '0;
      rs1_data_q  <= '0;
      rs1_idx_q   <= '0;
      rd_idx_q    <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      rs1_data_q  <= rs1_data_d;
      rs1_idx_q   <= rs1_idx_d;
      rd_idx_q    <= rd_idx_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_resp = (state_q == ST_RESP);

  // ready is held low while reset is asserted so every output reads 0 in reset
  assign req_ready_o   = rst_n_i && (state_q == ST_IDLE);
  assign csr_en_o      = en;
  assign csr_op_o      = dec_op;
  assign csr_addr_o    = addr_q;
  assign csr_data_o    = dec_operand;
  assign rsp_valid_o   = in_resp;
  assign rsp_rd_we_o   = in_resp && !illegal_q && (rd_idx_q != '0);
  assign rsp_rd_idx_o  = in_resp ? rd_idx_q : '0;
  assign rsp_rd_data_o = (in_resp && !illegal_q) ? rdata_q : '0;
  assign rsp_illegal_o = in_resp && illegal_q;
  assign rsp_timeout_o = in_resp && timeout_q;

  // write intent only feeds the decode's own illegality; keep it observable for debug
  logic unused_ok;
  assign unused_ok = dec_write_intent;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a CSR file model answers requests, and a
// funct3-level reference model predicts latency, rd writeback and the CSR's new value.
module tb_csr_access_unit;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_rs1_data;
  logic [4:0]    req_rs1_idx, req_rd_idx;
  logic          csr_en;
  logic [1:0]    csr_op;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata, csr_rdata;
  logic          csr_busy, csr_exists, csr_ro;
  logic          rsp_valid, rsp_we, rsp_ill, rsp_to;
  logic [4:0]    rsp_idx;
  logic [DW-1:0] rsp_data;

  int total = 0;
  int bad   = 0;
  int blen  = 2;

  always #5 clk = ~clk;

  csr_access_unit #(.CSR_DATA_WIDTH(DW), .CSR_ADDR_WIDTH(AW), .BUSY_TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
`ifdef CSR_PRIV_CHECK_EN
    .priv_i         (2'b11),
`endif
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_funct3_i   (req_funct3),
    .req_addr_i     (req_addr),
    .req_rs1_data_i (req_rs1_data),
    .req_rs1_idx_i  (req_rs1_idx),
    .req_rd_idx_i   (req_rd_idx),
    .csr_en_o       (csr_en),
    .csr_op_o       (csr_op),
    .csr_addr_o     (csr_addr),
    .csr_data_o     (csr_wdata),
    .csr_data_i     (csr_rdata),
    .csr_busy_i     (csr_busy),
    .csr_exists_i   (csr_exists),
    .csr_ro_i       (csr_ro),
    .rsp_valid_o    (rsp_valid),
    .rsp_rd_we_o    (rsp_we),
    .rsp_rd_idx_o   (rsp_idx),
    .rsp_rd_data_o  (rsp_data),
    .rsp_illegal_o  (rsp_ill),
    .rsp_timeout_o  (rsp_to)
  );

  // ---------------- CSR file model ----------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 12'h340) ? 32'h1234_5678 : (32'h9E37_79B9 ^ {20'h0, a});
  endfunction
  function automatic logic a_exists(input logic [AW-1:0] a);
    return (a != 12'h123) && (a != 12'h5A5);
  endfunction
  function automatic logic a_ro(input logic [AW-1:0] a);
    return a == 12'h7C0;
  endfunction

  logic [DW-1:0] mem     [0:4095];
  bit            written [0:4095];
  logic [DW-1:0] old_q;
  int            bcnt;

  function automatic logic [DW-1:0] file_rd(input logic [AW-1:0] a);
    return written[a] ? mem[a] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] file_apply(input logic [1:0] op,
                                               input logic [DW-1:0] o, d);
    case (op)
      2'd0:    return o | d;
      2'd1:    return d;
      2'd2:    return o & ~d;
      default: return o;
    endcase
  endfunction

  assign csr_exists = a_exists(csr_addr);
  assign csr_ro     = a_ro(csr_addr);
  assign csr_busy   = (bcnt > 0);
  assign csr_rdata  = old_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= 0;
      old_q <= '0;
    end else begin
      if (bcnt > 0) bcnt <= bcnt - 1;
      if (csr_en) begin
        old_q             <= file_rd(csr_addr);
        mem[csr_addr]     <= file_apply(csr_op, file_rd(csr_addr), csr_wdata);
        written[csr_addr] <= 1'b1;
        bcnt              <= blen;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:4095];
  bit            ref_wr  [0:4095];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [4:0] ri,
                         input logic [4:0] rdi, input int bl);
    logic          kind_w, kind_s, is_rd_only, wi, ill, tmo;
    logic [DW-1:0] operand, old, nv;
    logic [1:0]    e_op;
    logic [DW-1:0] e_data;
    int            e_lat;
    int            en_cnt, en_cyc, rsp_cyc;
    logic          stable, ready1;
    logic [1:0]    op_s;
    logic [DW-1:0] data_s, rdata_s;
    logic          we_s, ill_s, to_s;
    logic [4:0]    idx_s;

    // instruction meaning, straight from the Zicsr rules
    kind_w     = (f3 == 3'b001) || (f3 == 3'b101);
    kind_s     = (f3 == 3'b010) || (f3 == 3'b110);
    operand    = f3[2] ? DW'(ri) : d;
    is_rd_only = !kind_w && (ri == 5'd0);
    wi         = kind_w || (ri != 5'd0);
    ill        = (f3 == 3'b000) || (f3 == 3'b100) || !a_exists(a) || a_ro(a) ||
                 (wi && (a >= 12'hC00));
    tmo        = !ill && ((bl == 0) || (bl >= TO));
    old        = ref_rd(a);
    if (kind_w)          begin e_op = 2'd1; e_data = operand; nv = operand;         end
    else if (is_rd_only) begin e_op = 2'd0; e_data = '0;      nv = old;             end
    else if (kind_s)     begin e_op = 2'd0; e_data = operand; nv = old | operand;   end
    else                 begin e_op = 2'd2; e_data = operand; nv = old & ~operand;  end
    e_lat = ill ? 2 : (tmo ? TO + 2 : 3 + bl);
    if (!ill) begin ref_mem[a] = nv; ref_wr[a] = 1'b1; end

    blen = bl;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a;
    req_rs1_data = d; req_rs1_idx = ri; req_rd_idx = rdi;
    chk({tag, " ready_idle"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    // junk on the request fields must be ignored while busy
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = AW'($urandom);
    req_rs1_data = $urandom; req_rs1_idx = 5'($urandom); req_rd_idx = 5'($urandom);

    en_cnt = 0; en_cyc = -1; rsp_cyc = -1; stable = 1'b1; ready1 = 1'b1;
    op_s = '0; data_s = '0; rdata_s = '0; we_s = 1'b0; ill_s = 1'b0; to_s = 1'b0; idx_s = '0;
    for (int c = 1; c <= TO + 6 && rsp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) ready1 = req_ready;
      if (csr_addr !== a) stable = 1'b0;
      if (en_cnt > 0 && (csr_op !== op_s || csr_wdata !== data_s)) stable = 1'b0;
      if (csr_en) begin
        en_cnt++; en_cyc = c; op_s = csr_op; data_s = csr_wdata;
      end
      if (rsp_valid) begin
        rsp_cyc = c; we_s = rsp_we; idx_s = rsp_idx; rdata_s = rsp_data;
        ill_s = rsp_ill; to_s = rsp_to;
      end
    end

    chk({tag, " ready_busy"}, ready1, 1'b0);
    chk({tag, " en_count"}, en_cnt, ill ? 0 : 1);
    chk({tag, " rsp_cycle"}, rsp_cyc, e_lat);
    chk({tag, " illegal"}, ill_s, ill || tmo);
    chk({tag, " timeout"}, to_s, tmo);
    chk({tag, " rd_we"}, we_s, !ill && !tmo && (rdi != 5'd0));
    chk({tag, " rd_data"}, rdata_s, (ill || tmo) ? '0 : old);
    chk({tag, " addr_stable"}, stable, 1'b1);
    chk({tag, " csr_value"}, file_rd(a), ref_rd(a));
    if (!ill) begin
      chk({tag, " en_cycle"}, en_cyc, 1);
      chk({tag, " op"}, op_s, e_op);
      chk({tag, " wdata"}, data_s, e_data);
    end
    if (!ill && !tmo) chk({tag, " rd_idx"}, idx_s, rdi);
    @(negedge clk);
    chk({tag, " ready_after"}, req_ready, 1'b1);
  endtask

  function automatic logic [AW-1:0] pick_addr(input int k);
    case (k)
      0: return 12'h340;
      1: return 12'h300;
      2: return 12'h305;
      3: return 12'hF14;
      4: return 12'hC00;
      5: return 12'h7C0;
      6: return 12'h123;
      7: return 12'hB00;
      default: return 12'hFFF;
    endcase
  endfunction

  logic [127:0] out_vec;
  assign out_vec = {39'h0, req_ready, csr_en, csr_op, csr_addr, csr_wdata, rsp_valid,
                    rsp_we, rsp_idx, rsp_data, rsp_ill, rsp_to};

  initial begin
    logic saw_rsp;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_data = '0; req_rs1_idx = '0; req_rd_idx = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1 chk("reset outputs", out_vec, '0);
    #1 rst_n = 1'b1;
    #1 chk("ready after release", req_ready, 1'b1);

    // directed cases
    run_txn("csrrw_340",   3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7,  5'd5, 2);
    run_txn("csrrs_read",  3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0,  5'd3, 2);
    run_txn("csrrwi_f14",  3'b101, 12'hF14, 32'h0,         5'h1F, 5'd4, 2);
    run_txn("csrrs_f14rd", 3'b010, 12'hF14, 32'h0,         5'd0,  5'd6, 2);
    run_txn("f3_100",      3'b100, 12'h340, 32'h1,         5'd1,  5'd1, 2);
    run_txn("f3_000",      3'b000, 12'h300, 32'h1,         5'd1,  5'd1, 2);
    run_txn("no_exist",    3'b001, 12'h123, 32'h55,        5'd2,  5'd2, 2);
    run_txn("ro_flag",     3'b010, 12'h7C0, 32'h0F,        5'd2,  5'd8, 2);
    run_txn("csrrc_305",   3'b011, 12'h305, 32'h0000_FF00, 5'd9,  5'd9, 3);
    run_txn("csrrsi_305",  3'b110, 12'h305, 32'h0,         5'h15, 5'd10, 1);
    run_txn("csrrci_305",  3'b111, 12'h305, 32'h0,         5'h01, 5'd11, 1);
    run_txn("rd_zero",     3'b001, 12'h300, 32'hA5A5_0001, 5'd4,  5'd0, 2);
    run_txn("never_busy",  3'b001, 12'h340, 32'h1111_2222, 5'd4,  5'd12, 0);
    run_txn("busy_to_m1",  3'b001, 12'h340, 32'h3333_4444, 5'd4,  5'd13, TO - 1);
    run_txn("busy_to",     3'b001, 12'h340, 32'h5555_6666, 5'd4,  5'd14, TO);

    // reset pulsed while the unit is in WAIT: read-only access so the CSR stays unchanged
    blen = 5;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'h300;
    req_rs1_data = '0; req_rs1_idx = 5'd0; req_rd_idx = 5'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midreset outputs", out_vec, '0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("midreset ready", req_ready, 1'b1);
    saw_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("midreset no_rsp", saw_rsp, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int bl;
      logic [4:0] ri, rdi;
      ri  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdi = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bl  = ($urandom_range(0, 9) == 0) ? TO * int'($urandom_range(0, 1))
                                        : int'($urandom_range(1, 4));
      run_txn($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)),
              pick_addr(int'($urandom_range(0, 8))), $urandom, ri, rdi, bl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
